// File: rtl/alarm_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alarm_pkg: shared time limits, set-FSM encodings and button indices
// Rev 1.0
// ----------------------------------------------------------------------------
package alarm_pkg;

  localparam int HOURS_PER_DAY = 24;
  localparam int MINS_PER_HOUR = 60;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
  localparam logic [1:0] REPEAT = 2'd2;

  localparam int BTN_SNOOZE = 0;
  localparam int BTN_CANCEL = 1;
  localparam int BTN_HR     = 2;
  localparam int BTN_MIN    = 3;

endpackage
`default_nettype wire

// File: rtl/btn_sync_edge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// btn_sync_edge: 2-flop synchronizer with synchronized level and rise pulse
// Rev 1.0
// ----------------------------------------------------------------------------
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= btn_raw;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign level = r_sync;
  assign rise  = r_sync & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/alarm_time_setter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alarm_time_setter: alarm hour/minute setting with auto-repeat, plus snooze
// Rev 1.0
// ----------------------------------------------------------------------------
module alarm_time_setter
  import alarm_pkg::*;
#(
  parameter int HOLD_CYCLES   = 500000,
  parameter int REPEAT_CYCLES = 100000,
  parameter int RESET_HR      = 6,
  parameter int RESET_MIN     = 0,
  parameter int SNOOZE_MIN    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn,
  input  logic       sw0,
  input  logic       alarm,
  output logic [5:0] a_hr,
  output logic [5:0] a_min,
  output logic       snooze_active
);

  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] c_hold_last = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] c_rep_last  = CW'(REPEAT_CYCLES - 1);
  localparam logic [5:0]    c_last_hr   = 6'(HOURS_PER_DAY - 1);
  localparam logic [5:0]    c_last_min  = 6'(MINS_PER_HOUR - 1);
  localparam logic [6:0]    c_mins      = 7'(MINS_PER_HOUR);
  localparam logic [6:0]    c_snooze    = 7'(SNOOZE_MIN);
  localparam logic [5:0]    c_reset_hr  = 6'(RESET_HR);
  localparam logic [5:0]    c_reset_min = 6'(RESET_MIN);

  logic [3:0] w_level;
  logic [3:0] w_rise;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
      btn_sync_edge u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn[gi]),
        .level   (w_level[gi]),
        .rise    (w_rise[gi])
      );
    end
  endgenerate

  logic w_unused;
  assign w_unused = ^w_level[BTN_CANCEL:BTN_SNOOZE];

  logic [1:0]    r_state;
  logic [1:0]    w_next_state;
  logic          r_sel_min;
  logic [CW-1:0] r_cnt;
  logic          w_inc;
  logic          w_inc_min;
  logic          w_cnt_clr;
  logic          w_cnt_en;
  logic          w_held;

  assign w_held = r_sel_min ? w_level[BTN_MIN] : w_level[BTN_HR];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_rise[BTN_HR] || w_rise[BTN_MIN]) w_next_state = HOLD;
      HOLD:    if (!w_held) w_next_state = IDLE;
               else if (r_cnt == c_hold_last) w_next_state = REPEAT;
      REPEAT:  if (!w_held) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Hour wins a same-cycle press; the other button is then ignored until re-pressed.
  always_comb begin
    w_inc     = 1'b0;
    w_inc_min = r_sel_min;
    w_cnt_clr = 1'b0;
    w_cnt_en  = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_clr = 1'b1;
        if (w_rise[BTN_HR]) begin
          w_inc     = 1'b1;
          w_inc_min = 1'b0;
        end else if (w_rise[BTN_MIN]) begin
          w_inc     = 1'b1;
          w_inc_min = 1'b1;
        end
      end
      HOLD, REPEAT: begin
        if (!w_held) begin
          w_cnt_clr = 1'b1;
        end else if (r_cnt == ((r_state == HOLD) ? c_hold_last : c_rep_last)) begin
          w_inc     = 1'b1;
          w_cnt_clr = 1'b1;
        end else begin
          w_cnt_en  = 1'b1;
        end
      end
      default: w_cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_sel_min <= 1'b0;
    end else begin
      if (w_cnt_clr)     r_cnt <= '0;
      else if (w_cnt_en) r_cnt <= r_cnt + CW'(1);
      if (r_state == IDLE && w_inc) r_sel_min <= w_inc_min;
    end
  end

  logic [5:0] r_base_hr;
  logic [5:0] r_base_min;
  logic [5:0] r_eff_hr;
  logic [5:0] r_eff_min;
  logic       r_snooze;

  logic [5:0] w_new_hr;
  logic [5:0] w_new_min;
  logic [6:0] w_sum_min;
  logic [6:0] w_wrap_min;
  logic       w_carry;
  logic [5:0] w_snz_hr;
  logic [5:0] w_snz_min;
  logic       w_cancel;
  logic       w_snooze_req;

  assign w_new_hr  = (w_inc && !w_inc_min) ?
                     ((r_base_hr == c_last_hr) ? 6'd0 : r_base_hr + 6'd1) : r_base_hr;
  assign w_new_min = (w_inc && w_inc_min) ?
                     ((r_base_min == c_last_min) ? 6'd0 : r_base_min + 6'd1) : r_base_min;

  assign w_sum_min  = {1'b0, r_eff_min} + c_snooze;
  assign w_wrap_min = w_sum_min - c_mins;
  assign w_carry    = (w_sum_min >= c_mins);
  assign w_snz_min  = w_carry ? w_wrap_min[5:0] : w_sum_min[5:0];
  assign w_snz_hr   = !w_carry ? r_eff_hr :
                      ((r_eff_hr == c_last_hr) ? 6'd0 : r_eff_hr + 6'd1);

  assign w_cancel     = w_rise[BTN_CANCEL] | ~sw0;
  assign w_snooze_req = w_rise[BTN_SNOOZE] & alarm & sw0;

  // A set increment already lands effective on the (new) base and clears
  // snooze, so a simultaneous cancel needs no separate handling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base_hr  <= c_reset_hr;
      r_base_min <= c_reset_min;
      r_eff_hr   <= c_reset_hr;
      r_eff_min  <= c_reset_min;
      r_snooze   <= 1'b0;
    end else if (w_inc) begin
      r_base_hr  <= w_new_hr;
      r_base_min <= w_new_min;
      r_eff_hr   <= w_new_hr;
      r_eff_min  <= w_new_min;
      r_snooze   <= 1'b0;
    end else if (w_cancel) begin
      r_eff_hr   <= r_base_hr;
      r_eff_min  <= r_base_min;
      r_snooze   <= 1'b0;
    end else if (w_snooze_req) begin
      r_eff_hr   <= w_snz_hr;
      r_eff_min  <= w_snz_min;
      r_snooze   <= 1'b1;
    end
  end

  assign a_hr          = r_eff_hr;
  assign a_min         = r_eff_min;
  assign snooze_active = r_snooze;

endmodule
`default_nettype wire

// File: tb/tb_alarm_time_setter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_alarm_time_setter: scenario tasks plus random traffic against a time model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_alarm_time_setter;

  localparam int HOLD = 8;
  localparam int REP  = 4;
  localparam int SNZ  = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn;
  logic       sw0;
  logic       alarm;
  logic [5:0] a_hr;
  logic [5:0] a_min;
  logic       snooze_active;

  always #5 clk = ~clk;

  alarm_time_setter #(
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REP),
    .RESET_HR      (6),
    .RESET_MIN     (0),
    .SNOOZE_MIN    (SNZ)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn           (btn),
    .sw0           (sw0),
    .alarm         (alarm),
    .a_hr          (a_hr),
    .a_min         (a_min),
    .snooze_active (snooze_active)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference: base/effective time in plain integers, button history as raw samples.
  int         m_bhr, m_bmin, m_ehr, m_emin;
  bit         m_snz;
  bit         m_holding;
  int         m_held;
  int         m_press;
  int         cyc;
  logic [3:0] s1, s2, s3;

  task automatic model_reset();
    m_bhr = 6; m_bmin = 0; m_ehr = 6; m_emin = 0; m_snz = 0;
    m_holding = 0; m_held = 2; m_press = 0;
    s1 = '0; s2 = '0; s3 = '0;
  endtask

  task automatic model_edge();
    logic [3:0] lvl, rise;
    bit inc_hr, inc_min;
    int el, total;
    cyc++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    // A raw level sampled two edges ago is what the design acts on now.
    lvl = s2;
    rise = s2 & ~s3;
    inc_hr = 0; inc_min = 0;
    if (m_holding) begin
      if (!lvl[m_held]) m_holding = 0;
      else begin
        el = cyc - m_press;
        if (el == HOLD || (el > HOLD && (el - HOLD) % REP == 0)) begin
          if (m_held == 2) inc_hr = 1; else inc_min = 1;
        end
      end
    end else if (rise[2]) begin
      inc_hr = 1; m_holding = 1; m_held = 2; m_press = cyc;
    end else if (rise[3]) begin
      inc_min = 1; m_holding = 1; m_held = 3; m_press = cyc;
    end
    if (inc_hr || inc_min) begin
      if (inc_hr) m_bhr = (m_bhr + 1) % 24;
      else        m_bmin = (m_bmin + 1) % 60;
      m_ehr = m_bhr; m_emin = m_bmin; m_snz = 0;
    end else if (rise[1] || !sw0) begin
      m_ehr = m_bhr; m_emin = m_bmin; m_snz = 0;
    end else if (rise[0] && alarm && sw0) begin
      total = (m_ehr * 60 + m_emin + SNZ) % 1440;
      m_ehr = total / 60; m_emin = total % 60; m_snz = 1;
    end
    s3 = s2; s2 = s1; s1 = btn;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic press(input int b);
    btn[b] = 1'b1; step();
    btn[b] = 1'b0; step(); step(); step();
  endtask

  task automatic set_time(input int h, input int m);
    sw0 = 1'b0; step(); sw0 = 1'b1; step();
    while (m_bhr != h) press(2);
    while (m_bmin != m) press(3);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    compared++;
    if (a_hr !== 6'd6 || a_min !== 6'd0 || snooze_active !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_state: got %0d:%0d s=%0d, expected 6:0 s=0", a_hr, a_min, snooze_active);
    end
    rst_n = 1'b1;
    repeat (20) step();
    compared++;
    if (a_hr !== 6'd6 || a_min !== 6'd0 || snooze_active !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_idle: got %0d:%0d s=%0d, expected 6:0 s=0", a_hr, a_min, snooze_active);
    end
  endtask

  task automatic test_minute_wrap();
    int exp_min [3];
    set_time(6, 58);
    for (int p = 0; p < 2; p++) begin
      exp_min[0] = 58 + p; exp_min[1] = 58 + p; exp_min[2] = (p == 0) ? 59 : 0;
      btn[3] = 1'b1;
      for (int i = 0; i < 3; i++) begin
        step();
        compared++;
        if (a_hr !== 6'd6 || a_min !== 6'(exp_min[i])) begin
          mismatched++;
          $display("FAIL min_wrap p%0d e%0d: got %0d:%0d, expected 6:%0d", p, i + 1, a_hr, a_min, exp_min[i]);
        end
      end
      btn[3] = 1'b0;
      repeat (4) step();
    end
  endtask

  task automatic test_autorepeat();
    set_time(22, 15);
    btn[2] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) btn[3] = 1'b1;
      if (i == 12) btn[3] = 1'b0;
      step();
      compared++;
      if (a_hr !== 6'(m_ehr) || a_min !== 6'd15) begin
        mismatched++;
        $display("FAIL autorepeat cyc%0d: got %0d:%0d, expected %0d:15", i, a_hr, a_min, m_ehr);
      end
      if (i == 2 || i == 10) begin
        compared++;
        if (a_hr !== ((i == 2) ? 6'd23 : 6'd0)) begin
          mismatched++;
          $display("FAIL autorepeat_mark cyc%0d: got hr %0d, expected %0d", i, a_hr, (i == 2) ? 23 : 0);
        end
      end
    end
    btn[2] = 1'b0;
    repeat (10) step();
    compared++;
    if (a_hr !== 6'd5 || a_min !== 6'd15) begin
      mismatched++;
      $display("FAIL autorepeat_final: got %0d:%0d, expected 5:15", a_hr, a_min);
    end
  endtask

  task automatic test_simultaneous();
    set_time(10, 10);
    btn[3:2] = 2'b11; step();
    btn[3:2] = 2'b00;
    repeat (4) step();
    compared++;
    if (a_hr !== 6'd11 || a_min !== 6'd10) begin
      mismatched++;
      $display("FAIL simultaneous: got %0d:%0d, expected 11:10", a_hr, a_min);
    end
    press(3);
    compared++;
    if (a_hr !== 6'd11 || a_min !== 6'd11) begin
      mismatched++;
      $display("FAIL simultaneous_min: got %0d:%0d, expected 11:11", a_hr, a_min);
    end
  endtask

  task automatic test_snooze();
    int exp_h [4] = '{0, 0, 23, 23};
    int exp_m [4] = '{3, 8, 58, 58};
    bit exp_s [4] = '{1, 1, 0, 0};
    set_time(23, 58);
    for (int k = 0; k < 4; k++) begin
      alarm = (k != 3);
      if (k == 2) begin
        sw0 = 1'b0; step(); sw0 = 1'b1;
      end else begin
        btn[0] = 1'b1; step(); btn[0] = 1'b0; step(); step();
      end
      compared++;
      if (a_hr !== 6'(exp_h[k]) || a_min !== 6'(exp_m[k]) || snooze_active !== exp_s[k]) begin
        mismatched++;
        $display("FAIL snooze k%0d: got %0d:%0d s=%0d, expected %0d:%0d s=%0d",
                 k, a_hr, a_min, snooze_active, exp_h[k], exp_m[k], exp_s[k]);
      end
      step();
    end
    alarm = 1'b0;
  endtask

  task automatic test_priority();
    set_time(7, 0);
    alarm = 1'b1;
    btn[0] = 1'b1; step(); btn[0] = 1'b0; step(); step();
    compared++;
    if (a_hr !== 6'd7 || a_min !== 6'd5 || snooze_active !== 1'b1) begin
      mismatched++;
      $display("FAIL priority_snooze: got %0d:%0d s=%0d, expected 7:5 s=1", a_hr, a_min, snooze_active);
    end
    step();
    btn[3] = 1'b1; btn[0] = 1'b1; step();
    btn[3] = 1'b0; btn[0] = 1'b0; step(); step();
    compared++;
    if (a_hr !== 6'd7 || a_min !== 6'd1 || snooze_active !== 1'b0) begin
      mismatched++;
      $display("FAIL priority_set: got %0d:%0d s=%0d, expected 7:1 s=0", a_hr, a_min, snooze_active);
    end
    repeat (3) step();
    alarm = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, (b >= 2) ? 19 : 7) == 0) btn[b] = ~btn[b];
      sw0   = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 9) == 0) alarm = ~alarm;
      rst_n = ($urandom_range(0, 499) != 0);
      step();
      compared++;
      if (a_hr !== 6'(m_ehr) || a_min !== 6'(m_emin) || snooze_active !== m_snz) begin
        mismatched++;
        $display("FAIL random cyc%0d: got %0d:%0d s=%0d, expected %0d:%0d s=%0d",
                 i, a_hr, a_min, snooze_active, m_ehr, m_emin, m_snz);
      end
    end
    btn = '0; rst_n = 1'b1; sw0 = 1'b1; alarm = 1'b0;
  endtask

  initial begin
    cyc   = 0;
    btn   = '0;
    sw0   = 1'b1;
    alarm = 1'b0;
    rst_n = 1'b0;
    model_reset();
    test_reset();
    test_minute_wrap();
    test_autorepeat();
    test_simultaneous();
    test_snooze();
    test_priority();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
